// File: rtl/imem_loader.sv
// Byte-stream IMEM loader: packs incoming bytes little-endian into 32-bit words
// and writes them to consecutive word-aligned IMEM addresses, holding the core while busy.
module imem_loader #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   base_addr,
  input  logic [15:0]           word_cnt,
  input  logic                  abort,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_wr_en,
  output logic [PC_WIDTH-1:0]   imem_wr_addr,
  output logic [INST_WIDTH-1:0] imem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_o
);

  // Handshake: a byte moves on a rising edge where byte_valid and byte_ready are both 1;
  // byte_ready is high for the whole of COLLECT and never depends on byte_valid.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state_q;
  logic [PC_WIDTH-1:0]     addr_q;
  logic [15:0]             cnt_q;
  logic [1:0]              byte_idx_q;
  logic [INST_WIDTH-1:0]   word_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (word_cnt != 16'd0) begin
              addr_q     <= base_addr & ~PC_WIDTH'(3);
              cnt_q      <= word_cnt;
              byte_idx_q <= 2'd0;
              word_q     <= '0;
              state_q    <= COLLECT;
            end else begin
              state_q <= DONE;
            end
          end
        end
        COLLECT: begin
          // abort wins over a byte presented in the same cycle
          if (abort) begin
            byte_idx_q <= 2'd0;
            word_q     <= '0;
            state_q    <= IDLE;
          end else if (byte_valid) begin
            word_q[{byte_idx_q, 3'b000} +: 8] <= byte_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            byte_idx_q <= 2'd0;
            word_q     <= '0;
            state_q    <= IDLE;
          end else begin
            addr_q     <= addr_q + PC_WIDTH'(4);
            cnt_q      <= cnt_q - 16'd1;
            byte_idx_q <= 2'd0;
            state_q    <= (cnt_q == 16'd1) ? DONE : COLLECT;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // An abort landing in the WRITE cycle itself must still kill the strobe.
  assign imem_wr_en   = (state_q == WRITE) && !abort;
  assign imem_wr_addr = addr_q;
  assign imem_wr_data = word_q;
  assign byte_ready   = (state_q == COLLECT);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load transactions plus directed abort/reset/latency sequences,
// with IMEM writes checked against a scoreboard queue.
module tb_imem_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_cnt;
  logic        abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_wr_en;
  logic [31:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        busy;
  logic        done;
  logic [1:0]  state_o;

  imem_loader #(.PC_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .word_cnt     (word_cnt),
    .abort        (abort),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .busy         (busy),
    .done         (done),
    .state_o      (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int write_cnt = 0;
  int done_cnt  = 0;
  logic [31:0] last_addr = '0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] base;
    logic [15:0] cnt;
    int          gap;
    bit          noisy;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_writes;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every IMEM write must match the head of exp_q
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (imem_wr_en === 1'b1) begin
        write_cnt++;
        last_addr = imem_wr_addr;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   imem_wr_addr, imem_wr_data);
        end else begin
          check("imem_write", {imem_wr_addr, imem_wr_data}, exp_q.pop_front());
        end
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  // driver tasks; called at posedge+1, return at posedge+1
  task automatic send_byte(input logic [7:0] d);
    int n;
    byte_valid = 1'b1;
    byte_data  = d;
    n = 0;
    @(negedge clk);
    while (byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) check("byte_ready_timeout", {63'd0, byte_ready}, 64'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic start_load(input logic [31:0] b, input logic [15:0] c);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    word_cnt  = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int wc0, dc0, n;
    logic [31:0] w;
    wc0 = write_cnt;
    dc0 = done_cnt;
    start_load(v.base, v.cnt);
    if (v.cnt == 16'd0) begin
      @(negedge clk);
      check($sformatf("v%0d_zero_done", idx), {63'd0, done}, 64'd1);
      check($sformatf("v%0d_zero_busy", idx), {63'd0, busy}, 64'd1);
      @(negedge clk);
      check($sformatf("v%0d_zero_done_end", idx), {63'd0, done}, 64'd0);
      check($sformatf("v%0d_zero_busy_end", idx), {63'd0, busy}, 64'd0);
    end else begin
      if (v.noisy) begin
        start     = 1'b1;
        base_addr = 32'hDEAD_0000;
        word_cnt  = 16'd9;
      end
      for (int i = 0; i < int'(v.cnt); i++) begin
        w = $urandom;
        exp_q.push_back({v.exp_first + 32'(4 * i), w});
        for (int b = 0; b < 4; b++) begin
          n = 0;
          while ($urandom_range(0, 99) < v.gap && n < 3) begin
            @(posedge clk);
            #1;
            n++;
          end
          send_byte(w[8*b +: 8]);
        end
      end
      start = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done !== 1'b1 && n < 30);
      check($sformatf("v%0d_done_seen", idx), {63'd0, done}, 64'd1);
      check($sformatf("v%0d_busy_at_done", idx), {63'd0, busy}, 64'd1);
      @(negedge clk);
      check($sformatf("v%0d_done_end", idx), {63'd0, done}, 64'd0);
      check($sformatf("v%0d_busy_after", idx), {63'd0, busy}, 64'd0);
      check($sformatf("v%0d_last_addr", idx), {32'd0, last_addr}, {32'd0, v.exp_last});
    end
    @(negedge clk);
    check($sformatf("v%0d_writes", idx), 64'(write_cnt - wc0), 64'(v.exp_writes));
    check($sformatf("v%0d_dones", idx), 64'(done_cnt - dc0), 64'd1);
    check($sformatf("v%0d_queue_empty", idx), 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int wc0, dc0;
    vecs[0] = '{32'h0000_0100, 16'd1, 0,  1'b0, 32'h0000_0100, 32'h0000_0100, 1};
    vecs[1] = '{32'h0000_0000, 16'd3, 40, 1'b0, 32'h0000_0000, 32'h0000_0008, 3};
    vecs[2] = '{32'h0000_0103, 16'd2, 0,  1'b0, 32'h0000_0100, 32'h0000_0104, 2};
    vecs[3] = '{32'hFFFF_FFFC, 16'd2, 20, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 2};
    vecs[4] = '{32'h0000_2001, 16'd4, 30, 1'b1, 32'h0000_2000, 32'h0000_200C, 4};
    vecs[5] = '{32'h0000_0040, 16'd0, 0,  1'b0, 32'h0000_0000, 32'h0000_0000, 0};

    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_cnt   = '0;
    abort      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_outputs", {59'd0, byte_ready, imem_wr_en, busy, done, 1'b0}, 64'd0);
    check("rst_wr_bus", {imem_wr_addr, imem_wr_data}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {61'd0, busy, state_o}, 64'd0);

    // single word, no gaps: write one cycle after 4th byte, done the cycle after
    start_load(32'h0000_0100, 16'd1);
    exp_q.push_back({32'h0000_0100, 32'h0010_0513});
    send_byte(8'h13);
    send_byte(8'h05);
    send_byte(8'h10);
    send_byte(8'h00);
    @(negedge clk);
    check("lat_write_cycle", {62'd0, imem_wr_en, done}, 64'd2);
    check("lat_write_state", 64'(state_o), 64'd2);
    @(negedge clk);
    check("lat_done_cycle", {62'd0, imem_wr_en, done}, 64'd1);
    @(negedge clk);
    check("lat_idle", {61'd0, done, state_o}, 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // abort after the 2nd byte of word 2, with a byte offered in the same cycle
    wc0 = write_cnt;
    dc0 = done_cnt;
    start_load(32'h0000_0300, 16'd4);
    exp_q.push_back({32'h0000_0300, 32'hA1B2_C3D4});
    send_byte(8'hD4);
    send_byte(8'hC3);
    send_byte(8'hB2);
    send_byte(8'hA1);
    send_byte(8'h11);
    send_byte(8'h22);
    abort      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h33;
    @(negedge clk);
    check("abort_no_write", {63'd0, imem_wr_en}, 64'd0);
    @(posedge clk);
    #1;
    abort      = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    check("abort_idle", {60'd0, busy, byte_ready, state_o}, 64'd0);
    repeat (6) @(negedge clk);
    check("abort_writes", 64'(write_cnt - wc0), 64'd1);
    check("abort_no_done", 64'(done_cnt - dc0), 64'd0);
    run_vec('{32'h0000_0300, 16'd1, 0, 1'b0, 32'h0000_0300, 32'h0000_0300, 1}, 10);

    // asynchronous reset in the middle of COLLECT
    wc0 = write_cnt;
    dc0 = done_cnt;
    start_load(32'h0000_0500, 16'd2);
    send_byte(8'h55);
    send_byte(8'h66);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_ctrl", {59'd0, byte_ready, imem_wr_en, busy, done, 1'b0}, 64'd0);
    check("async_rst_state", 64'(state_o), 64'd0);
    check("async_rst_bus", {imem_wr_addr, imem_wr_data}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_mid_no_write", 64'(write_cnt - wc0), 64'd0);
    check("rst_mid_no_done", 64'(done_cnt - dc0), 64'd0);
    check("rst_mid_idle", {61'd0, busy, state_o}, 64'd0);
    run_vec('{32'h0000_0504, 16'd2, 25, 1'b1, 32'h0000_0504, 32'h0000_0508, 2}, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion, expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter PC_WIDTH, default 32: width of the IMEM byte address.
REQ-002 Parameter INST_WIDTH, default 32: width of the IMEM data word; fixed at 4 bytes.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous and active-low.
REQ-005 start  input  1  load request; sampled only in IDLE.
REQ-006 base_addr  input  PC_WIDTH  first IMEM byte address; latched on an accepted start.
REQ-007 word_cnt  input  16  number of words to load; latched on an accepted start.
REQ-008 abort  input  1  cancels a load in progress.
REQ-009 byte_valid  input  1  source presents a byte.
REQ-010 byte_data  input  8  byte payload.
REQ-011 byte_ready  output  1  loader accepts the byte this cycle.
REQ-012 imem_wr_en  output  1  IMEM write strobe.
REQ-013 imem_wr_addr  output  PC_WIDTH  IMEM write byte address.
REQ-014 imem_wr_data  output  INST_WIDTH  IMEM write word.
REQ-015 busy  output  1  load in progress; the core holds its PC (pc_write low) while this is high.
REQ-016 done  output  1  single-cycle pulse when a load completes.

Function
REQ-017 The FSM SHALL have four states: IDLE, COLLECT, WRITE and DONE.
REQ-018 IDLE with start=1 and word_cnt!=0 SHALL latch base_addr (with bits [1:0] forced to 0) and word_cnt, then go to COLLECT.
REQ-019 IDLE with start=1 and word_cnt=0 SHALL go directly to DONE without any IMEM write.
REQ-020 A byte SHALL transfer only in a cycle where byte_valid=1 and byte_ready=1.
REQ-021 byte_ready SHALL be 1 only in COLLECT.
REQ-022 Bytes SHALL be packed little-endian: the 1st byte goes to bits [7:0] and the 4th to bits [31:24].
REQ-023 A 2-bit byte index SHALL advance on each transfer.
REQ-024 After the 4th byte of a word, the next state SHALL be WRITE.
REQ-025 In WRITE, imem_wr_en SHALL be 1 for exactly one cycle, with imem_wr_addr equal to the current address and imem_wr_data equal to the assembled word.
REQ-026 imem_wr_en SHALL be 0 in every state other than WRITE.
REQ-027 On leaving WRITE, the address SHALL increase by 4, wrapping modulo 2^PC_WIDTH, and the remaining count SHALL decrement by 1.
REQ-028 On leaving WRITE, the next state SHALL be DONE if the remaining count reaches 0, otherwise COLLECT with the byte index reset to 0.
REQ-029 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-030 Latency: a write occurs 1 cycle after its 4th byte is accepted, and done occurs 1 cycle after the final write.
REQ-031 Throughput SHALL be a minimum of 5 cycles per word.
REQ-032 busy SHALL be 1 in COLLECT, WRITE and DONE, and 0 in IDLE.
REQ-033 start outside IDLE SHALL be ignored, with no effect on the load in progress.
REQ-034 abort=1 in COLLECT or WRITE SHALL go to IDLE next cycle, discard any partial word, and suppress both the WRITE-state write and done.
REQ-035 abort SHALL take priority over a simultaneous byte transfer.
REQ-036 abort in IDLE or DONE SHALL be ignored.
REQ-037 byte_valid=0 in COLLECT SHALL hold all state, with no timeout.

Reset
REQ-038 While reset_n=0, the state SHALL be IDLE and byte_ready, imem_wr_en, busy and done SHALL all be 0.
REQ-039 While reset_n=0, imem_wr_addr, imem_wr_data, the byte index and the remaining count SHALL all be 0.
REQ-040 Reset asserted mid-load SHALL take effect immediately (asynchronously), discard the load, and produce no done pulse.
REQ-041 After reset release, the block SHALL wait in IDLE for start.

Verification
REQ-042 Single word, no gaps: start with base_addr=0x100, word_cnt=1, then bytes 0x13,0x05,0x10,0x00. Required response: one write of addr 0x100, data 0x00100513, and done exactly 2 cycles after the 4th byte.
REQ-043 Three words with random byte_valid gaps: required response is writes at 0x0, 0x4 and 0x8 with correctly packed data, a single done pulse, and busy high from the cycle after start until the cycle after done.
REQ-044 word_cnt=0: required response is done 1 cycle after start, no write, and busy high for exactly 1 cycle.
REQ-045 Unaligned base_addr=0x103 with wrap at base_addr=0xFFFFFFFC, word_cnt=2: required response is the first write at 0x100 (case 0x103), and for the wrap case writes at 0xFFFFFFFC then 0x00000000.
REQ-046 abort after the 2nd byte of word 2 (word_cnt=4): required response is exactly 1 write, no done, IDLE next cycle, and a fresh start then loads correctly from a byte index of 0.
REQ-047 reset_n pulsed low mid-COLLECT: required response is all outputs 0 immediately, no write and no done, and start ignored while busy is confirmed in the same run.
